// File: rtl/iod_delay_line_sequencer.sv
// iod_delay_line_sequencer
// Drives one IOD lane's dynamic delay line. It takes tap-adjust commands over
// a valid/ready handshake and turns them into spaced LOAD / MOVE / DIRECTION
// strobes. It tracks the current tap and aborts a command on OUT_OF_RANGE.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RST_LOAD | issue the single LOAD pulse (after reset or a LOAD command)
// LOAD_GAP | quiet cycles after LOAD
// IDLE     | ready for a command
// SETUP    | DIRECTION settles one cycle before the first MOVE
// PULSE    | MOVE high for one cycle
// GAP      | quiet cycles after MOVE; OUT_OF_RANGE is watched here
// FIN      | DONE/ERR pulse
//
// Ports:
//   FAB_CLK, SYNC_RST_N          clock, synchronous active-low reset
//   REQ_VALID/REQ_READY          command handshake
//   REQ_CMD[1:0], REQ_ARG[7:0]   00 LOAD, 01 INC, 10 DEC, 11 GOTO
//   DONE, ERR                    completion pulse; ERR=1 means aborted
//   BUSY, CUR_TAP[7:0]           status
//   DELAY_LINE_LOAD/MOVE/DIRECTION, DELAY_LINE_OUT_OF_RANGE   IOD side
module iod_delay_line_sequencer #(
    parameter int TAP_MAX   = 255,
    parameter int RESET_TAP = 1,
    parameter int STEP_GAP  = 4
) (
    input  logic       FAB_CLK,
    input  logic       SYNC_RST_N,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic [1:0] REQ_CMD,
    input  logic [7:0] REQ_ARG,
    output logic       DONE,
    output logic       ERR,
    output logic       BUSY,
    output logic [7:0] CUR_TAP,
    output logic       DELAY_LINE_LOAD,
    output logic       DELAY_LINE_MOVE,
    output logic       DELAY_LINE_DIRECTION,
    input  logic       DELAY_LINE_OUT_OF_RANGE
);

    localparam logic [7:0] TAP_MAX_V   = 8'(TAP_MAX);
    localparam logic [7:0] RESET_TAP_V = 8'(RESET_TAP);
    localparam logic [3:0] GAP_INIT    = 4'(STEP_GAP - 1);

    typedef enum logic [2:0] {
        RST_LOAD, LOAD_GAP, IDLE, SETUP, PULSE, GAP, FIN
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] gap_q, gap_d;
    logic [7:0] count_q, count_d;
    logic [7:0] tap_q, tap_d;
    logic       dir_q, dir_d;
    logic       oor_q, oor_d;
    logic       from_cmd_q, from_cmd_d;
    logic       err_d;
    logic       ready_q, done_q, err_q, busy_q, load_q, move_q;

    logic [8:0] diff9;
    logic [7:0] step_cnt;
    logic       oor_now;
    logic [7:0] tap_step;

    function automatic logic at_limit(input logic [7:0] tap, input logic dir);
        return dir ? (tap == TAP_MAX_V) : (tap == 8'd0);
    endfunction

    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        count_d    = count_q;
        tap_d      = tap_q;
        dir_d      = dir_q;
        oor_d      = oor_q;
        from_cmd_d = from_cmd_q;
        err_d      = 1'b0;
        diff9      = {1'b0, REQ_ARG} - {1'b0, tap_q};
        step_cnt   = 8'd0;
        oor_now    = oor_q | DELAY_LINE_OUT_OF_RANGE;
        tap_step   = dir_q ? (tap_q + 8'd1) : (tap_q - 8'd1);

        case (state_q)
            RST_LOAD: begin
                // load_q marks the LOAD pulse as already issued; coming out of
                // reset it is still low, so one more cycle here emits it.
                if (load_q) begin
                    state_d = LOAD_GAP;
                    gap_d   = GAP_INIT;
                end
            end
            LOAD_GAP: begin
                if (gap_q == 4'd0) begin
                    state_d    = from_cmd_q ? FIN : IDLE;
                    from_cmd_d = 1'b0;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            IDLE: begin
                if (REQ_VALID && ready_q) begin
                    case (REQ_CMD)
                        2'b00: begin
                            state_d    = RST_LOAD;
                            tap_d      = RESET_TAP_V;
                            from_cmd_d = 1'b1;
                        end
                        2'b01: begin
                            dir_d    = 1'b1;
                            step_cnt = REQ_ARG;
                        end
                        2'b10: begin
                            dir_d    = 1'b0;
                            step_cnt = REQ_ARG;
                        end
                        default: begin
                            dir_d    = !diff9[8] && (diff9 != 9'd0);
                            step_cnt = diff9[8] ? 8'(-diff9) : diff9[7:0];
                        end
                    endcase
                    if (REQ_CMD != 2'b00) begin
                        count_d = step_cnt;
                        state_d = (step_cnt == 8'd0) ? FIN : SETUP;
                    end
                end
            end
            SETUP: begin
                if (at_limit(tap_q, dir_q)) begin
                    state_d = FIN;
                    err_d   = 1'b1;
                end else begin
                    state_d = PULSE;
                end
            end
            PULSE: begin
                state_d = GAP;
                gap_d   = GAP_INIT;
                oor_d   = 1'b0;
            end
            GAP: begin
                oor_d = oor_now;
                if (gap_q != 4'd0) begin
                    gap_d = gap_q - 4'd1;
                end else if (oor_now) begin
                    state_d = FIN;
                    err_d   = 1'b1;
                end else begin
                    tap_d   = tap_step;
                    count_d = count_q - 8'd1;
                    if (count_q == 8'd1) begin
                        state_d = FIN;
                    end else if (at_limit(tap_step, dir_q)) begin
                        // range pre-check for the next pulse, taken in its slot
                        state_d = FIN;
                        err_d   = 1'b1;
                    end else begin
                        state_d = PULSE;
                    end
                end
            end
            FIN: state_d = IDLE;
            default: state_d = RST_LOAD;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge FAB_CLK) begin
        if (!SYNC_RST_N) begin
            state_q    <= RST_LOAD;
            gap_q      <= 4'd0;
            count_q    <= 8'd0;
            tap_q      <= RESET_TAP_V;
            dir_q      <= 1'b0;
            oor_q      <= 1'b0;
            from_cmd_q <= 1'b0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b1;
            load_q     <= 1'b0;
            move_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            count_q    <= count_d;
            tap_q      <= tap_d;
            dir_q      <= dir_d;
            oor_q      <= oor_d;
            from_cmd_q <= from_cmd_d;
            ready_q    <= (state_d == IDLE);
            done_q     <= (state_d == FIN);
            err_q      <= err_d;
            busy_q     <= (state_d != IDLE);
            load_q     <= (state_d == RST_LOAD);
            move_q     <= (state_d == PULSE);
        end
    end

    assign REQ_READY            = ready_q;
    assign DONE                 = done_q;
    assign ERR                  = err_q;
    assign BUSY                 = busy_q;
    assign CUR_TAP              = tap_q;
    assign DELAY_LINE_LOAD      = load_q;
    assign DELAY_LINE_MOVE      = move_q;
    assign DELAY_LINE_DIRECTION = dir_q;

endmodule

// File: tb/tb_iod_delay_line_sequencer.sv
// Directed bench for iod_delay_line_sequencer. Expected command results are
// queued when a command is driven and popped when DONE appears.
module tb_iod_delay_line_sequencer;

    localparam int G         = 4;
    localparam int TAP_MAX   = 255;
    localparam int RESET_TAP = 1;

    logic       FAB_CLK = 1'b0;
    logic       SYNC_RST_N = 1'b0;
    logic       REQ_VALID = 1'b0;
    logic       REQ_READY;
    logic [1:0] REQ_CMD = 2'b00;
    logic [7:0] REQ_ARG = 8'd0;
    logic       DONE, ERR, BUSY;
    logic [7:0] CUR_TAP;
    logic       DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION;
    logic       DELAY_LINE_OUT_OF_RANGE = 1'b0;

    iod_delay_line_sequencer #(
        .TAP_MAX(TAP_MAX), .RESET_TAP(RESET_TAP), .STEP_GAP(G)
    ) dut (
        .FAB_CLK(FAB_CLK),
        .SYNC_RST_N(SYNC_RST_N),
        .REQ_VALID(REQ_VALID),
        .REQ_READY(REQ_READY),
        .REQ_CMD(REQ_CMD),
        .REQ_ARG(REQ_ARG),
        .DONE(DONE),
        .ERR(ERR),
        .BUSY(BUSY),
        .CUR_TAP(CUR_TAP),
        .DELAY_LINE_LOAD(DELAY_LINE_LOAD),
        .DELAY_LINE_MOVE(DELAY_LINE_MOVE),
        .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION),
        .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    typedef struct {
        int done_cyc;
        int err;
        int tap;
        int moves;
        int dir;
        int load_cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   model_tap = RESET_TAP;

    task automatic check(input string tag, input int observed, input int expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Reference behaviour for one command starting from model_tap.
    function automatic exp_t predict(input logic [1:0] cmd, input int arg, input int oor_gap);
        exp_t e;
        int   n, tap, p, dir;
        e.load_cyc = -1;
        e.dir      = -1;
        e.err      = 0;
        e.moves    = 0;
        e.tap      = model_tap;
        if (cmd == 2'b00) begin
            e.load_cyc = 1;
            e.done_cyc = 2 + G;
            e.tap      = RESET_TAP;
            return e;
        end
        if (cmd == 2'b01) begin dir = 1; n = arg; end
        else if (cmd == 2'b10) begin dir = 0; n = arg; end
        else if (arg > model_tap) begin dir = 1; n = arg - model_tap; end
        else begin dir = 0; n = model_tap - arg; end
        e.dir = dir;
        if (n == 0) begin
            e.done_cyc = 1;
            return e;
        end
        tap = model_tap;
        p = 0;
        for (int s = 0; s < n; s++) begin
            if ((dir == 1 && tap == TAP_MAX) || (dir == 0 && tap == 0)) begin
                e.err = 1;
                break;
            end
            p++;
            if (p == oor_gap) begin
                e.err = 1;
                break;
            end
            tap = dir ? tap + 1 : tap - 1;
        end
        e.tap      = tap;
        e.moves    = p;
        e.done_cyc = 2 + p * (G + 1);
        return e;
    endfunction

    // Entered and left at a falling edge. oor_gap=k forces OUT_OF_RANGE
    // high through the k-th GAP.
    task automatic do_cmd(input logic [1:0] cmd, input int arg, input int oor_gap, input string tag);
        exp_t e, x;
        int   w, moves, load_at, done_at, prev_dir;
        e = predict(cmd, arg, oor_gap);
        sb_q.push_back(e);
        w = 0;
        while (!REQ_READY && w < 200) begin
            @(negedge FAB_CLK);
            w++;
        end
        check({tag, " ready_before"}, int'(REQ_READY), 1);
        REQ_CMD   = cmd;
        REQ_ARG   = 8'(arg);
        REQ_VALID = 1'b1;
        @(posedge FAB_CLK);
        #1 REQ_VALID = 1'b0;
        moves = 0; load_at = -1; done_at = -1; prev_dir = -1;
        for (int c = 1; c <= e.done_cyc + 20 && done_at < 0; c++) begin
            @(negedge FAB_CLK);
            if (DELAY_LINE_MOVE) begin
                moves++;
                check({tag, " move_cycle"}, c, 2 + (moves - 1) * (G + 1));
                check({tag, " dir_at_move"}, int'(DELAY_LINE_DIRECTION), e.dir);
                check({tag, " dir_before_move"}, prev_dir, e.dir);
            end
            if (DELAY_LINE_LOAD && load_at < 0) load_at = c;
            if (DONE) begin
                done_at = c;
                x = sb_q.pop_front();
                check({tag, " done_cycle"}, c, x.done_cyc);
                check({tag, " err"}, int'(ERR), x.err);
                check({tag, " cur_tap"}, int'(CUR_TAP), x.tap);
                check({tag, " move_count"}, moves, x.moves);
                check({tag, " load_cycle"}, load_at, x.load_cyc);
                check({tag, " busy_at_done"}, int'(BUSY), 1);
            end
            prev_dir = int'(DELAY_LINE_DIRECTION);
            DELAY_LINE_OUT_OF_RANGE = (oor_gap != 0) && (moves == oor_gap) && !DELAY_LINE_MOVE;
        end
        DELAY_LINE_OUT_OF_RANGE = 1'b0;
        if (done_at < 0) begin
            check({tag, " done_timeout"}, done_at, e.done_cyc);
            if (sb_q.size() > 0) sb_q.delete(sb_q.size() - 1);
        end
        @(negedge FAB_CLK);
        check({tag, " ready_after"}, int'(REQ_READY), 1);
        check({tag, " done_one_cycle"}, int'(DONE), 0);
        check({tag, " busy_idle"}, int'(BUSY), 0);
        model_tap = e.tap;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " rst_ready"}, int'(REQ_READY), 0);
        check({tag, " rst_done"}, int'(DONE), 0);
        check({tag, " rst_err"}, int'(ERR), 0);
        check({tag, " rst_busy"}, int'(BUSY), 1);
        check({tag, " rst_load"}, int'(DELAY_LINE_LOAD), 0);
        check({tag, " rst_move"}, int'(DELAY_LINE_MOVE), 0);
        check({tag, " rst_dir"}, int'(DELAY_LINE_DIRECTION), 0);
        check({tag, " rst_tap"}, int'(CUR_TAP), RESET_TAP);
    endtask

    // Called at a falling edge with reset held for at least one rising edge.
    task automatic release_and_check(input string tag);
        int load_n, load_at, ready_at, done_n, move_n;
        check_reset_values(tag);
        load_n = 0; load_at = -1; ready_at = -1; done_n = 0; move_n = 0;
        SYNC_RST_N = 1'b1;
        for (int c = 0; c <= G + 3; c++) begin
            @(negedge FAB_CLK);
            if (DELAY_LINE_LOAD) begin
                load_n++;
                if (load_at < 0) load_at = c;
            end
            if (REQ_READY && ready_at < 0) ready_at = c;
            if (DONE) done_n++;
            if (DELAY_LINE_MOVE) move_n++;
        end
        check({tag, " load_pulses"}, load_n, 1);
        check({tag, " load_cycle"}, load_at, 0);
        check({tag, " ready_cycle"}, ready_at, G + 1);
        check({tag, " no_done"}, done_n, 0);
        check({tag, " no_move"}, move_n, 0);
        check({tag, " tap"}, int'(CUR_TAP), RESET_TAP);
        model_tap = RESET_TAP;
    endtask

    initial begin
        int moves, dones;
        repeat (3) @(negedge FAB_CLK);
        release_and_check("por");

        do_cmd(2'b01, 3,   0, "inc3");
        do_cmd(2'b11, 0,   0, "goto0");
        do_cmd(2'b10, 1,   0, "dec1_at_zero");
        do_cmd(2'b11, 10,  0, "goto10");
        do_cmd(2'b01, 5,   3, "inc5_oor");
        do_cmd(2'b11, 12,  0, "goto_same");
        do_cmd(2'b01, 0,   0, "inc0");
        do_cmd(2'b11, 255, 0, "goto_max");
        do_cmd(2'b01, 1,   0, "inc_at_max");
        do_cmd(2'b00, 0,   0, "load");
        do_cmd(2'b10, 2,   0, "dec2_from1");
        do_cmd(2'b01, 2,   0, "inc2");

        // Reset during the second GAP of INC 4.
        moves = 0; dones = 0;
        REQ_CMD = 2'b01; REQ_ARG = 8'd4; REQ_VALID = 1'b1;
        @(posedge FAB_CLK);
        #1 REQ_VALID = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge FAB_CLK);
            if (DELAY_LINE_MOVE) moves++;
            if (DONE) dones++;
        end
        check("midrst moves_before", moves, 2);
        SYNC_RST_N = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge FAB_CLK);
            if (DELAY_LINE_MOVE) moves++;
            if (DONE) dones++;
        end
        check("midrst moves_total", moves, 2);
        check("midrst no_done", dones, 0);
        release_and_check("midrst");
        do_cmd(2'b01, 1, 0, "after_rst_inc1");

        check("scoreboard_empty", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
